// File: rtl/xor_table_lookup_uram.sv
// Lookup pipeline for the XOR-encoded multi-write-port hash table: reads all banks,
// XOR-recovers the entry word, forwards in-flight writes and compares the key.
module xor_table_lookup_uram #(
  parameter int unsigned NUM_WR      = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned VALUE_WIDTH = 31,
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_in,
  input  logic [1:0]                   opt_in,
  input  logic [INDEX_WIDTH-1:0]       index_in,
  input  logic [KEY_WIDTH-1:0]         key_in,
  output logic                         bank_rd_en,
  output logic [INDEX_WIDTH-1:0]       bank_rd_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] bank_rd_data,
  input  logic                         wr_en,
  input  logic [INDEX_WIDTH-1:0]       wr_index,
  input  logic [DATA_WIDTH-1:0]        wr_word,
  output logic                         out_valid,
  output logic                         out_hit,
  output logic [VALUE_WIDTH-1:0]       out_value,
  output logic [KEY_WIDTH-1:0]         out_key,
  output logic [INDEX_WIDTH-1:0]       out_index
);

  localparam int unsigned ValidBit  = KEY_WIDTH + VALUE_WIDTH;
  // Stage 0 is the issue register, 1..RD_LATENCY the delay line, the last is the XOR stage.
  localparam int unsigned NumStages = RD_LATENCY + 2;
  localparam int unsigned XorStage  = NumStages - 1;

  typedef struct packed {
    logic                   valid;
    logic [INDEX_WIDTH-1:0] index;
    logic [KEY_WIDTH-1:0]   key;
    logic                   fwd_hit;
    logic [DATA_WIDTH-1:0]  fwd_word;
  } entry_t;

  entry_t pipe_q [NumStages];
  entry_t pipe_d [NumStages];
  entry_t fwd    [NumStages];

  logic [DATA_WIDTH-1:0] rec_q, rec_d;
  logic                  accept;

  logic                   bank_rd_en_q;
  logic [INDEX_WIDTH-1:0] bank_rd_addr_q;

  logic                   out_valid_q;
  logic                   out_hit_q, out_hit_d;
  logic [VALUE_WIDTH-1:0] out_value_q, out_value_d;
  logic [KEY_WIDTH-1:0]   out_key_q;
  logic [INDEX_WIDTH-1:0] out_index_q;
  logic [DATA_WIDTH-1:0]  eff_word;

  assign accept = en_in && (opt_in == 2'b00);

  // A write committing this cycle overrides whatever an in-flight entry already holds.
  always_comb begin
    for (int unsigned s = 0; s < NumStages; s++) begin
      fwd[s] = pipe_q[s];
      if (pipe_q[s].valid && wr_en && (wr_index == pipe_q[s].index)) begin
        fwd[s].fwd_hit  = 1'b1;
        fwd[s].fwd_word = wr_word;
      end
    end
  end

  always_comb begin
    pipe_d[0]          = '0;
    pipe_d[0].valid    = accept;
    pipe_d[0].index    = index_in;
    pipe_d[0].key      = key_in;
    for (int unsigned s = 1; s < NumStages; s++) begin
      pipe_d[s] = fwd[s-1];
    end
  end

  always_comb begin
    rec_d = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      rec_d = rec_d ^ bank_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    eff_word    = fwd[XorStage].fwd_hit ? fwd[XorStage].fwd_word : rec_q;
    out_hit_d   = eff_word[ValidBit] && (eff_word[KEY_WIDTH-1:0] == fwd[XorStage].key);
    out_value_d = out_hit_d ? eff_word[ValidBit-1:KEY_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NumStages; s++) begin
        pipe_q[s] <= '0;
      end
      rec_q          <= '0;
      bank_rd_en_q   <= 1'b0;
      bank_rd_addr_q <= '0;
    end else begin
      for (int unsigned s = 0; s < NumStages; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
      rec_q        <= rec_d;
      bank_rd_en_q <= accept;
      if (accept) begin
        bank_rd_addr_q <= index_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_value_q <= '0;
      out_key_q   <= '0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= fwd[XorStage].valid;
      if (fwd[XorStage].valid) begin
        out_hit_q   <= out_hit_d;
        out_value_q <= out_value_d;
        out_key_q   <= fwd[XorStage].key;
        out_index_q <= fwd[XorStage].index;
      end
    end
  end

  assign bank_rd_en   = bank_rd_en_q;
  assign bank_rd_addr = bank_rd_addr_q;
  assign out_valid    = out_valid_q;
  assign out_hit      = out_hit_q;
  assign out_value    = out_value_q;
  assign out_key      = out_key_q;
  assign out_index    = out_index_q;

endmodule

// File: tb/tb_xor_table_lookup_uram.sv
// Scoreboard bench: a read-first XOR-scattered bank model feeds the DUT; expected
// results are queued at issue and resolved against the table contents at output time.
module tb_xor_table_lookup_uram;

  localparam int NW = 8;
  localparam int IW = 12;
  localparam int VW = 31;
  localparam int KW = 32;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam logic [KW-1:0] FwdKey = 32'hCAFE_0009;

  logic              clk = 1'b0;
  logic              reset;
  logic              en_in;
  logic [1:0]        opt_in;
  logic [IW-1:0]     index_in;
  logic [KW-1:0]     key_in;
  logic              bank_rd_en;
  logic [IW-1:0]     bank_rd_addr;
  logic [NW*DW-1:0]  bank_rd_data;
  logic              wr_en;
  logic [IW-1:0]     wr_index;
  logic [DW-1:0]     wr_word;
  logic              out_valid;
  logic              out_hit;
  logic [VW-1:0]     out_value;
  logic [KW-1:0]     out_key;
  logic [IW-1:0]     out_index;

  always #5 clk = ~clk;

  xor_table_lookup_uram #(
    .NUM_WR(NW), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .KEY_WIDTH(KW),
    .DATA_WIDTH(DW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .en_in(en_in), .opt_in(opt_in), .index_in(index_in),
    .key_in(key_in), .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
    .bank_rd_data(bank_rd_data), .wr_en(wr_en), .wr_index(wr_index), .wr_word(wr_word),
    .out_valid(out_valid), .out_hit(out_hit), .out_value(out_value), .out_key(out_key),
    .out_index(out_index)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [KW-1:0] key;
    int            due;
    logic          xchk;
    logic          xhit;
    logic [VW-1:0] xval;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic [DW-1:0]    mem [0:31];
  logic [NW*DW-1:0] rd_pipe [0:RL-1];

  function automatic logic [NW*DW-1:0] scatter(input logic [DW-1:0] w);
    logic [NW*DW-1:0] v;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    r;
    acc = w;
    for (int j = 0; j < NW - 1; j++) begin
      r = {$urandom, $urandom};
      v[j*DW +: DW] = r;
      acc = acc ^ r;
    end
    v[(NW-1)*DW +: DW] = acc;
    return v;
  endfunction

  // Read-first banks: the read sees the table before a same-edge write lands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe[0] <= bank_rd_en ? scatter(mem[bank_rd_addr[4:0]]) : '0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (wr_en) mem[wr_index[4:0]] <= wr_word;
  end

  assign bank_rd_data = rd_pipe[RL-1];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [DW-1:0] w;
    logic          ehit;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("out_timing", 64'(cyc), 64'(e.due));
        w    = mem[e.idx[4:0]];
        ehit = w[KW+VW] && (w[KW-1:0] == e.key);
        check_eq("out_hit", 64'(out_hit), 64'(ehit));
        check_eq("out_value", 64'(out_value), ehit ? 64'(w[KW+VW-1:KW]) : 64'd0);
        check_eq("out_key", 64'(out_key), 64'(e.key));
        check_eq("out_index", 64'(out_index), 64'(e.idx));
        if (e.xchk) begin
          check_eq("directed_hit", 64'(out_hit), 64'(e.xhit));
          check_eq("directed_value", 64'(out_value), 64'(e.xval));
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check_eq("missing_out_valid", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
  end

  task automatic drive(input logic en, input logic [1:0] opt, input logic [IW-1:0] idx,
                       input logic [KW-1:0] key, input logic we, input logic [IW-1:0] widx,
                       input logic [DW-1:0] wword, input logic xchk, input logic xhit,
                       input logic [VW-1:0] xval);
    exp_t e;
    en_in = en; opt_in = opt; index_in = idx; key_in = key;
    wr_en = we; wr_index = widx; wr_word = wword;
    if (en && opt == 2'b00 && !reset) begin
      e.idx = idx; e.key = key; e.due = cyc + 3 + RL;
      e.xchk = xchk; e.xhit = xhit; e.xval = xval;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [DW-1:0] word);
    drive(1'b0, 2'b00, '0, '0, 1'b1, idx, word, 1'b0, 1'b0, '0);
  endtask

  task automatic look(input logic [IW-1:0] idx, input logic [KW-1:0] key, input logic xchk,
                      input logic xhit, input logic [VW-1:0] xval);
    drive(1'b1, 2'b00, idx, key, 1'b0, '0, '0, xchk, xhit, xval);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_hit"}, 64'(out_hit), 64'd0);
    check_eq({tag, "_out_value"}, 64'(out_value), 64'd0);
    check_eq({tag, "_out_key"}, 64'(out_key), 64'd0);
    check_eq({tag, "_out_index"}, 64'(out_index), 64'd0);
    check_eq({tag, "_bank_rd_en"}, 64'(bank_rd_en), 64'd0);
    check_eq({tag, "_bank_rd_addr"}, 64'(bank_rd_addr), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    en_in = 1'b0; opt_in = 2'b00; index_in = '0; key_in = '0;
    wr_en = 1'b0; wr_index = '0; wr_word = '0;
    @(negedge clk);
    idle(2);
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 32; i++) wr(IW'(i), '0);
    idle(2);

    // Hit, key mismatch, deleted entry.
    wr(12'd5, {1'b1, 31'h0ABC, 32'hDEAD_BEEF});
    wr(12'd6, {1'b0, 31'h55, 32'h1234_5678});
    look(12'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 31'h0ABC);
    look(12'd5, 32'h1, 1'b1, 1'b0, '0);
    look(12'd6, 32'h1234_5678, 1'b1, 1'b0, '0);
    idle(8);

    // Forwarding: latest of two in-flight writes wins.
    look(12'd9, FwdKey, 1'b1, 1'b0, '0);
    idle(1);
    wr(12'd9, {1'b1, 31'h7, FwdKey});
    idle(1);
    wr(12'd9, {1'b0, 31'h0, FwdKey});
    idle(8);
    // Single in-flight write is forwarded.
    look(12'd9, FwdKey, 1'b1, 1'b1, 31'h7);
    idle(1);
    wr(12'd9, {1'b1, 31'h7, FwdKey});
    idle(8);
    // Write in the issue cycle reaches the banks before the read.
    drive(1'b1, 2'b00, 12'd9, FwdKey, 1'b1, 12'd9, {1'b1, 31'h33, FwdKey}, 1'b1, 1'b1, 31'h33);
    idle(8);

    // Back-to-back throughput.
    for (int i = 0; i < 16; i++) wr(IW'(i), {1'(i % 2), 31'(i * 3 + 1), 32'(i)});
    idle(2);
    for (int i = 0; i < 16; i++)
      look(IW'(i), KW'(i), 1'b1, 1'(i % 2), (i % 2 == 1) ? VW'(i * 3 + 1) : '0);
    idle(8);

    // Non-read opcodes are ignored.
    for (int o = 1; o < 4; o++) begin
      drive(1'b1, 2'(o), 12'd3, 32'd3, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      check_eq("opcode_bank_rd_en", 64'(bank_rd_en), 64'd0);
    end
    idle(8);

    // Random lookups and writes over a small index range to exercise forwarding.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
            IW'($urandom_range(0, 7)), KW'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)),
            {1'($urandom_range(0, 1)), 31'($urandom), 32'($urandom_range(0, 3))},
            1'b0, 1'b0, '0);
    end
    idle(8);

    // Reset with lookups in flight.
    wr(12'd20, {1'b1, 31'h0ABC, 32'hDEAD_BEEF});
    look(12'd1, 32'd1, 1'b0, 1'b0, '0);
    look(12'd2, 32'd2, 1'b0, 1'b0, '0);
    look(12'd3, 32'd3, 1'b0, 1'b0, '0);
    reset = 1'b1;
    sb.delete();
    idle(1);
    reset = 1'b0;
    check_reset_state("midreset");
    idle(7);
    look(12'd20, 32'hDEAD_BEEF, 1'b1, 1'b1, 31'h0ABC);
    idle(8);

    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xor_table_lookup_uram.md
# xor_table_lookup_URAM

Read/lookup side of the XOR-encoded multi-write-port hash table held in URAM banks. It accepts one lookup per cycle and issues the table index to all NUM_WR banks of its read port. It XORs the NUM_WR returned words to recover the stored entry word {valid, value, key}, then compares the key to produce hit/value. In-flight writes from the companion write pipeline are forwarded so that a lookup never returns data older than a write committed after the lookup was issued.

## Interface
Parameters:
- NUM_WR, 8, number of write ports, which is also the number of banks XORed per read
- INDEX_WIDTH, 12, table address width
- VALUE_WIDTH, 31, value field width
- KEY_WIDTH, 32, key field width
- DATA_WIDTH, 64, stored word width; must be ≥ KEY_WIDTH+VALUE_WIDTH+1
- RD_LATENCY, 2, bank read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en_in  in  1  request strobe
- opt_in  in  2  opcode; only 2'b00 (read) starts a lookup
- index_in  in  INDEX_WIDTH  table index
- key_in  in  KEY_WIDTH  lookup key
- bank_rd_en  out  1  registered read enable to all banks
- bank_rd_addr  out  INDEX_WIDTH  registered read address to all banks
- bank_rd_data  in  NUM_WR*DATA_WIDTH  bank read data; bank j occupies [j*DATA_WIDTH +: DATA_WIDTH]
- wr_en  in  1  plain write committing this cycle
- wr_index  in  INDEX_WIDTH  address of that write
- wr_word  in  DATA_WIDTH  un-XORed entry word of that write: {valid, value, key}
- out_valid  out  1  result strobe, one cycle
- out_hit  out  1  stored valid bit = 1 and stored key == requested key
- out_value  out  VALUE_WIDTH  stored value field; 0 when out_hit = 0
- out_key  out  KEY_WIDTH  echo of the requested key
- out_index  out  INDEX_WIDTH  echo of the requested index

## Operation
- Entry word layout: bit KEY_WIDTH+VALUE_WIDTH = valid; [KEY_WIDTH+VALUE_WIDTH-1:KEY_WIDTH] = value; [KEY_WIDTH-1:0] = key. Bits above the valid bit are ignored.
- A lookup is accepted when en_in = 1 and opt_in = 2'b00. Any other opt_in with en_in = 1 is ignored: no bank read and no result. There is no backpressure; one lookup can be accepted every cycle.
- Pipeline: issue register, then an RD_LATENCY delay line, then the XOR stage, then the compare/output register. Each pipeline entry carries {valid, index, key, fwd_hit, fwd_word}.
- XOR stage: the recovered word is the bitwise XOR of all NUM_WR slices of bank_rd_data.
- Forwarding:
  - Each cycle, every valid entry from the issue register through the XOR-stage register compares wr_index to its index.
  - On wr_en and a match, the entry sets fwd_hit = 1 and fwd_word = wr_word. The latest write wins.
  - The compare stage also checks the current-cycle wr_en/wr_index combinationally, with the same priority.
- Compare: effective word = fwd_hit ? fwd_word : recovered word. out_hit = eff.valid & (eff.key == key). out_value is masked to 0 on a miss.
- Reset clears all pipeline valid bits, bank_rd_en, and every output. Lookups in flight at reset are dropped with no result.

## Timing
- Lookup sampled at edge ending cycle t. bank_rd_en/bank_rd_addr are valid in cycle t+1.
- bank_rd_data is valid in cycle t+1+RD_LATENCY and is sampled at the end of that cycle. The XOR register is valid in t+2+RD_LATENCY.
- Outputs are valid in cycle t+3+RD_LATENCY (t+5 at default). Fixed latency; results come out in order.
- Writes with wr_en in cycles t+1 through t+2+RD_LATENCY inclusive are forwarded. A write in cycle t or earlier is visible through the banks, which are read-first.
- Reset values: bank_rd_en = 0, bank_rd_addr = 0, out_valid = 0, out_hit = 0, out_value = 0, out_key = 0, out_index = 0.
- Reset asserted in cycle r: no out_valid in cycles r+1 .. r+3+RD_LATENCY unless a new lookup is accepted after reset deasserts.

## Test plan
- Hit: bank slices XOR to {1, 31'h0ABC, 32'hDEAD_BEEF} at index 5; lookup (5, 32'hDEADBEEF) -> out_valid 5 cycles later, out_hit = 1, out_value = 31'h0ABC, out_index = 5.
- Key mismatch and deleted entry: same data, lookup key 32'h1 -> out_hit = 0, out_value = 0. Stored valid bit = 0 with matching key -> out_hit = 0.
- Forwarding: lookup index 9 at t; banks return a miss. wr_en with wr_index = 9 and wr_word = {1, 31'h7, key} at t+2, then a second write {0, 0, key} at t+4 -> out_hit = 0 (latest wins). Repeat with only the t+2 write -> hit, value 7. A write at cycle t -> not forwarded; bank data is used.
- Throughput: lookups every cycle for 16 cycles at indices 0..15 -> 16 consecutive out_valid pulses, in order, with matching out_index.
- Opcode filter: en_in = 1 with opt_in = 01, 10, 11 -> bank_rd_en stays 0 and no out_valid.
- Reset mid-flight: 3 lookups issued, then reset asserted for 1 cycle -> no out_valid for those lookups, all outputs 0. A lookup issued after reset completes normally.
